// File: rtl/capture_rle_store_pkg.sv
// capture_rle_store_pkg: FSM state encoding and word geometry shared by the capture store
package capture_rle_store_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/capture_rle_store_fifo.sv
// capture_rle_store_fifo: synchronous word FIFO with flush; head word read straight from the storage registers
module capture_rle_store_fifo
    import capture_rle_store_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = WORD_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  logic [W-1:0] i_data,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic          w_push;
    logic          w_pop;

    assign o_empty = (r_wr == r_rd);
    assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign o_data  = r_mem[r_rd[AW-1:0]];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Storage array; an extra pointer bit tells full from empty
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
    end

    // Read/write pointers; flush empties the FIFO and wins over a same-cycle push
    always_ff @(posedge clk_i) begin
        if (!rst_i || i_flush) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + PW'(1);
            if (w_pop)  r_rd <= r_rd + PW'(1);
        end
    end
endmodule

// File: rtl/capture_rle_store.sv
// capture_rle_store: buffers RLE words and writes them to a one-shot or ring region of sample memory (option: CAPTURE_RLE_STORE_STATS_EN adds a drop counter)
module capture_rle_store
    import capture_rle_store_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              input_valid_i,
    input  logic [WORD_W-1:0] input_data_i,
    input  logic              cfg_enable_i,
    input  logic              cfg_cont_i,
    input  logic [ADDR_W-1:0] cfg_base_i,
    input  logic [ADDR_W-1:0] cfg_size_i,
    output logic              mem_wr_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [WORD_W-1:0] mem_data_o,
    input  logic              mem_accept_i,
    output logic              sts_busy_o,
    output logic              sts_done_o,
    output logic              sts_wrapped_o,
    output logic              sts_overflow_o,
    output logic [ADDR_W-1:0] sts_count_o,
`ifdef CAPTURE_RLE_STORE_STATS_EN
    output logic [15:0]       sts_drop_count_o,
`endif
    output logic [ADDR_W-1:0] sts_wr_ptr_o
);
    state_t            r_state;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_size;
    logic              r_cont;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_count;
    logic              r_wrapped;
    logic              r_overflow;
    logic              w_full;
    logic              w_empty;
    logic [WORD_W-1:0] w_head;
    logic              w_busy;
    logic              w_wr;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_last;
    logic              w_start;
    logic              w_flush;

    assign w_busy  = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_wr    = w_busy && !w_empty;
    assign w_pop   = w_wr && mem_accept_i;
    assign w_push  = (r_state == ST_RUN) && input_valid_i && !w_full;
    assign w_drop  = (r_state == ST_RUN) && input_valid_i && w_full;
    assign w_last  = w_pop && (r_idx == r_size - ADDR_W'(1));
    assign w_start = (r_state == ST_IDLE) && cfg_enable_i;
    assign w_flush = w_start || (w_last && !r_cont);

    capture_rle_store_fifo #(.DEPTH(FIFO_DEPTH), .W(WORD_W)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  (input_data_i),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_data  (w_head)
    );

    assign mem_wr_o       = w_wr;
    assign mem_addr_o     = r_ptr;
    assign mem_data_o     = w_wr ? w_head : '0;
    assign sts_busy_o     = w_busy;
    assign sts_done_o     = (r_state == ST_DONE);
    assign sts_wrapped_o  = r_wrapped;
    assign sts_overflow_o = r_overflow;
    assign sts_count_o    = r_count;
    assign sts_wr_ptr_o   = r_ptr;

    // Run-control FSM plus region pointer, progress count and sticky status
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state    <= ST_IDLE;
            r_base     <= '0;
            r_size     <= '0;
            r_cont     <= 1'b0;
            r_idx      <= '0;
            r_ptr      <= '0;
            r_count    <= '0;
            r_wrapped  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pop) begin
                r_count   <= (&r_count) ? r_count : r_count + ADDR_W'(1);
                r_idx     <= w_last ? '0 : r_idx + ADDR_W'(1);
                r_ptr     <= (w_last && r_cont) ? r_base : r_ptr + ADDR_W'(BYTES_PER_WORD);
                r_wrapped <= r_wrapped | (w_last && r_cont);
            end
            if (w_drop) r_overflow <= 1'b1;
            case (r_state)
                ST_IDLE: if (cfg_enable_i) begin
                    r_base     <= cfg_base_i & ~ADDR_W'(3);
                    r_size     <= cfg_size_i;
                    r_cont     <= cfg_cont_i;
                    r_idx      <= '0;
                    r_ptr      <= cfg_base_i & ~ADDR_W'(3);
                    r_count    <= '0;
                    r_wrapped  <= 1'b0;
                    r_overflow <= 1'b0;
                    r_state    <= (cfg_size_i == '0) ? ST_DONE : ST_RUN;
                end
                ST_RUN:   r_state <= (w_last && !r_cont) ? ST_DONE : cfg_enable_i ? ST_RUN : ST_DRAIN;
                ST_DRAIN: r_state <= ((w_last && !r_cont) || w_empty) ? ST_DONE : ST_DRAIN;
                default:  r_state <= cfg_enable_i ? ST_DONE : ST_IDLE;
            endcase
        end
    end

`ifdef CAPTURE_RLE_STORE_STATS_EN
    logic [15:0] r_drop;

    assign sts_drop_count_o = r_drop;

    // Saturating count of words dropped on a full FIFO since the run started
    always_ff @(posedge clk_i) begin
        if (!rst_i || w_start) r_drop <= '0;
        else if (w_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
    end
`endif
endmodule

// File: tb/tb_capture_rle_store.sv
// tb_capture_rle_store: directed and randomised checks of the RLE capture store
module tb_capture_rle_store;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        input_valid_i = 1'b0;
    logic [31:0] input_data_i = '0;
    logic        cfg_enable_i = 1'b0;
    logic        cfg_cont_i = 1'b0;
    logic [31:0] cfg_base_i = '0;
    logic [31:0] cfg_size_i = '0;
    logic        mem_wr_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_accept_i = 1'b0;
    logic        sts_busy_o;
    logic        sts_done_o;
    logic        sts_wrapped_o;
    logic        sts_overflow_o;
    logic [31:0] sts_count_o;
    logic [31:0] sts_wr_ptr_o;
`ifdef CAPTURE_RLE_STORE_STATS_EN
    logic [15:0] sts_drop_count_o;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic [31:0] ex[$];
    int          mq;
    logic        movf;

    capture_rle_store dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .input_valid_i    (input_valid_i),
        .input_data_i     (input_data_i),
        .cfg_enable_i     (cfg_enable_i),
        .cfg_cont_i       (cfg_cont_i),
        .cfg_base_i       (cfg_base_i),
        .cfg_size_i       (cfg_size_i),
        .mem_wr_o         (mem_wr_o),
        .mem_addr_o       (mem_addr_o),
        .mem_data_o       (mem_data_o),
        .mem_accept_i     (mem_accept_i),
        .sts_busy_o       (sts_busy_o),
        .sts_done_o       (sts_done_o),
        .sts_wrapped_o    (sts_wrapped_o),
        .sts_overflow_o   (sts_overflow_o),
        .sts_count_o      (sts_count_o),
`ifdef CAPTURE_RLE_STORE_STATS_EN
        .sts_drop_count_o (sts_drop_count_o),
`endif
        .sts_wr_ptr_o     (sts_wr_ptr_o)
    );

    always #5 clk_i = ~clk_i;

    // Log every accepted memory write in order
    always @(posedge clk_i) begin
        if (rst_i && mem_wr_o && mem_accept_i) begin
            wa.push_back(mem_addr_o);
            wd.push_back(mem_data_o);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wr"}, {31'd0, mem_wr_o}, 0);
        check({tag, "_addr"}, mem_addr_o, 0);
        check({tag, "_data"}, mem_data_o, 0);
        check({tag, "_busy"}, {31'd0, sts_busy_o}, 0);
        check({tag, "_done"}, {31'd0, sts_done_o}, 0);
        check({tag, "_wrap"}, {31'd0, sts_wrapped_o}, 0);
        check({tag, "_ovf"}, {31'd0, sts_overflow_o}, 0);
        check({tag, "_cnt"}, sts_count_o, 0);
        check({tag, "_ptr"}, sts_wr_ptr_o, 0);
    endtask

    task automatic start(input logic [31:0] base, input logic [31:0] size, input logic cont);
        cfg_base_i   = base;
        cfg_size_i   = size;
        cfg_cont_i   = cont;
        cfg_enable_i = 1'b1;
        wa.delete();
        wd.delete();
        tick();
    endtask

    task automatic push_words(input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            input_valid_i = 1'b1;
            input_data_i  = first + 32'(i);
            tick();
        end
        input_valid_i = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        check_zero("rst");
        rst_i = 1'b1;

        // one-shot, 4-word region, 6 words offered
        mem_accept_i = 1'b1;
        start(32'h1000, 4, 1'b0);
        check("os_busy", {31'd0, sts_busy_o}, 1);
        push_words(32'hA0, 6);
        repeat (3) tick();
        check("os_done", {31'd0, sts_done_o}, 1);
        check("os_busy2", {31'd0, sts_busy_o}, 0);
        check("os_cnt", sts_count_o, 4);
        check("os_wrap", {31'd0, sts_wrapped_o}, 0);
        check("os_ptr", sts_wr_ptr_o, 32'h1010);
        check("os_nwr", 32'(wa.size()), 4);
        for (int i = 0; i < 4 && i < wa.size(); i++) begin
            check("os_addr", wa[i], 32'h1000 + 32'(4 * i));
            check("os_data", wd[i], 32'hA0 + 32'(i));
        end
        cfg_enable_i = 1'b0;
        tick();
        check("os_idle", {31'd0, sts_done_o}, 0);

        // continuous ring of 3 words, 7 words offered
        start(32'h2000, 3, 1'b1);
        push_words(32'hB0, 7);
        repeat (4) tick();
        check("ct_nwr", 32'(wa.size()), 7);
        for (int i = 0; i < 7 && i < wa.size(); i++) begin
            check("ct_addr", wa[i], 32'h2000 + 32'(4 * (i % 3)));
            check("ct_data", wd[i], 32'hB0 + 32'(i));
        end
        check("ct_wrap", {31'd0, sts_wrapped_o}, 1);
        check("ct_cnt", sts_count_o, 7);
        check("ct_ptr", sts_wr_ptr_o, 32'h2004);
        check("ct_busy", {31'd0, sts_busy_o}, 1);
        cfg_enable_i = 1'b0;
        repeat (2) tick();
        check("ct_done", {31'd0, sts_done_o}, 1);
        tick();

        // backpressure: nothing accepted for 20 cycles while 12 words arrive
        mem_accept_i = 1'b0;
        start(32'h3000, 64, 1'b0);
        for (int i = 0; i < 20; i++) begin
            input_valid_i = (i < 12);
            input_data_i  = 32'hC0 + 32'(i);
            tick();
            check("bp_wr", {31'd0, mem_wr_o}, 1);
            check("bp_addr", mem_addr_o, 32'h3000);
            check("bp_data", mem_data_o, 32'hC0);
        end
        input_valid_i = 1'b0;
        check("bp_ovf", {31'd0, sts_overflow_o}, 1);
`ifdef CAPTURE_RLE_STORE_STATS_EN
        check("bp_drop", {16'd0, sts_drop_count_o}, 4);
`endif
        mem_accept_i = 1'b1;
        repeat (10) tick();
        check("bp_nwr", 32'(wa.size()), 8);
        for (int i = 0; i < 8 && i < wa.size(); i++) begin
            check("bp_waddr", wa[i], 32'h3000 + 32'(4 * i));
            check("bp_wdata", wd[i], 32'hC0 + 32'(i));
        end
        check("bp_cnt", sts_count_o, 8);
        cfg_enable_i = 1'b0;
        repeat (3) tick();

        // disable with 3 words buffered, then drain; re-enable ignored until enable drops
        mem_accept_i = 1'b0;
        start(32'h4000, 16, 1'b0);
        push_words(32'hD0, 3);
        cfg_enable_i = 1'b0;
        tick();
        check("dr_busy", {31'd0, sts_busy_o}, 1);
        check("dr_wr", {31'd0, mem_wr_o}, 1);
        check("dr_data", mem_data_o, 32'hD0);
        cfg_enable_i = 1'b1;
        mem_accept_i = 1'b1;
        repeat (3) tick();
        check("dr_busy2", {31'd0, sts_busy_o}, 1);
        tick();
        check("dr_done", {31'd0, sts_done_o}, 1);
        check("dr_nwr", 32'(wa.size()), 3);
        for (int i = 0; i < 3 && i < wa.size(); i++) begin
            check("dr_addr", wa[i], 32'h4000 + 32'(4 * i));
            check("dr_wdata", wd[i], 32'hD0 + 32'(i));
        end
        repeat (2) tick();
        check("dr_hold", {31'd0, sts_done_o}, 1);
        cfg_enable_i = 1'b0;
        tick();
        check("dr_idle", {31'd0, sts_done_o | sts_busy_o}, 0);

        // zero-size region goes straight to DONE without writing
        input_valid_i = 1'b1;
        input_data_i  = 32'hEE;
        start(32'h5000, 0, 1'b0);
        check("z_done", {31'd0, sts_done_o}, 1);
        for (int i = 0; i < 3; i++) begin
            check("z_wr", {31'd0, mem_wr_o}, 0);
            tick();
        end
        check("z_nwr", 32'(wa.size()), 0);
        input_valid_i = 1'b0;
        cfg_enable_i  = 1'b0;
        tick();

        // reset in the middle of a run
        mem_accept_i = 1'b0;
        start(32'h5000, 8, 1'b0);
        push_words(32'hE0, 2);
        check("mr_wr", {31'd0, mem_wr_o}, 1);
        rst_i        = 1'b0;
        cfg_enable_i = 1'b0;
        tick();
        check_zero("mr");
        rst_i = 1'b1;

        // random traffic into a 64-word ring against a FIFO occupancy model
        start(32'h6000, 64, 1'b1);
        ex.delete();
        mq   = 0;
        movf = 1'b0;
        for (int i = 0; i < 400; i++) begin
            input_valid_i = ($urandom_range(0, 9) < 3);
            input_data_i  = $urandom;
            mem_accept_i  = $urandom_range(0, 1) == 1;
            begin
                int s0;
                s0 = mq;
                if (mem_accept_i && s0 > 0) mq--;
                if (input_valid_i) begin
                    if (s0 < 8) begin
                        mq++;
                        ex.push_back(input_data_i);
                    end else movf = 1'b1;
                end
            end
            tick();
        end
        input_valid_i = 1'b0;
        mem_accept_i  = 1'b1;
        repeat (20) tick();
        check("rn_nwr", 32'(wa.size()), 32'(ex.size()));
        for (int i = 0; i < ex.size() && i < wa.size(); i++) begin
            check("rn_addr", wa[i], 32'h6000 + 32'(4 * (i % 64)));
            check("rn_data", wd[i], ex[i]);
        end
        check("rn_cnt", sts_count_o, 32'(ex.size()));
        check("rn_ovf", {31'd0, sts_overflow_o}, {31'd0, movf});
        check("rn_wrap", {31'd0, sts_wrapped_o}, {31'd0, ex.size() >= 64});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
